// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM burst reader.
//   ADDR_W_DEF / DATA_W_DEF / RD_LAT_DEF : default geometry and BRAM read latency
//   state_t                              : burst FSM state encoding
//   fifo_depth()                         : capture FIFO depth for a given read latency
package bram_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;
   localparam int RD_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One slot per beat that can be in the BRAM pipeline plus one being presented.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 1;
   endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Small capture FIFO for BRAM read data.
//   clk, rst   : clock, synchronous active-high reset (clears storage and pointers)
//   push/wdata : write one entry (ignored when full unless a pop happens in the same cycle)
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry, stable until popped
//   count      : number of entries held
module bram_rd_fifo
   import bram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = fifo_depth(RD_LAT_DEF),
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count
);

   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_END = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [DATA_W-1:0] store [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = store[rd_ptr];

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_END) ? '0 : p + PTR_ONE;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr] <= wdata;
            wr_ptr        <= ptr_next(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bram_burst_reader.sv
// Reads a burst of consecutive BRAM locations and presents them as a
// valid/ready stream.
//   clk, rst             : clock, synchronous active-high reset
//   start                : burst request, only looked at while idle
//   base_addr, length    : first address and beat count (0..2^ADDR_W)
//   mem_addr, mem_data   : BRAM read port (data arrives RD_LAT cycles after the address)
//   m_data/m_valid/m_ready/m_last : output stream, m_last marks the final beat
//   busy, done           : burst in progress / one-cycle completion pulse
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing addresses as FIFO credit allows
// ST_DRAIN | every address issued, beats still to be delivered
// ST_DONE  | single-cycle completion, returns to idle
module bram_burst_reader
   import bram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = fifo_depth(RD_LAT);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   issue_cnt;
   logic [ADDR_W:0]   beat_cnt;
   logic [RD_LAT-1:0] tag_sr;
   logic [CW-1:0]     fifo_count;
   logic              pop;
   logic              push;
   logic              issue;
   logic              last_issue;
   logic              credit_ok;
   int                in_flight;

   // The issue decision is made in the same cycle the address is on mem_addr,
   // so credit counts only the reads already in the BRAM pipeline. Whatever
   // m_ready does afterwards, everything outstanding fits in the FIFO.
   always_comb begin
      in_flight = 0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + int'(tag_sr[i]);
      credit_ok = (int'(fifo_count) + in_flight - int'(pop)) < DEPTH;
   end

   assign issue      = (state == ST_RUN) && credit_ok;
   assign last_issue = (issue_cnt == len_q - LEN_ONE);
   assign push       = tag_sr[RD_LAT-1];
   assign m_valid    = (fifo_count != '0);
   assign pop        = m_valid && m_ready;
   assign m_last     = m_valid && (beat_cnt == len_q - LEN_ONE);

   bram_rd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (mem_data),
      .pop   (pop),
      .head  (m_data),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         len_q     <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         mem_addr  <= '0;
         tag_sr    <= '0;
      end else begin
         tag_sr[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) tag_sr[i] <= tag_sr[i-1];

         // mem_addr always shows the address being issued; after the final
         // issue it is left on the last address of the burst.
         if (issue) begin
            issue_cnt <= issue_cnt + LEN_ONE;
            if (!last_issue) mem_addr <= mem_addr + ADDR_ONE;
         end
         if (pop) beat_cnt <= beat_cnt + LEN_ONE;

         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state     <= ST_RUN;
                     busy      <= 1'b1;
                     len_q     <= length;
                     mem_addr  <= base_addr;
                     issue_cnt <= '0;
                     beat_cnt  <= '0;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (issue && last_issue) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && m_last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: BRAM model with fixed read latency, a
// queue-based model of the expected stream and busy/done behaviour, and
// directed literal checks on top of randomized bursts.
module tb_bram_burst_reader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic              busy;
   logic              done;

   bram_burst_reader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM: registered read, data RD_LAT cycles after the address cycle.
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data = rd_pipe[RD_LAT-1];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model state
   logic              exp_busy = 1'b0;
   logic              exp_done = 1'b0;
   logic              n_busy;
   logic              n_done;
   logic [DATA_W-1:0] exp_q [$];
   int                exp_len;
   int                beat_idx;
   int                acc_cyc;
   int                done_cyc;
   logic [DATA_W-1:0] got_q [$];
   int                got_cyc [$];
   logic [ADDR_W-1:0] addr_q [$];
   logic              prev_stall;
   logic [DATA_W-1:0] prev_data;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         exp_busy = n_busy;
         exp_done = n_done;
      end
   end

   initial begin
      logic last_xfer;
      n_busy     = 1'b0;
      n_done     = 1'b0;
      prev_stall = 1'b0;
      acc_cyc    = 0;
      done_cyc   = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            n_busy     = 1'b0;
            n_done     = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
         end else begin
            last_xfer = 1'b0;
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("fifo_bound", dut.fifo_count <= 3, 1);
            if (prev_stall) begin
               chk("hold_valid", m_valid, 1);
               chk("hold_data", m_data, prev_data);
            end
            if (!m_valid) chk("last_idle", m_last, 0);
            if (exp_q.size() == 0) begin
               chk("no_beat", m_valid, 0);
            end else if (m_valid) begin
               chk("data", m_data, exp_q[0]);
               chk("last", m_last, beat_idx == exp_len - 1);
               chk("latency", (cyc - acc_cyc) >= beat_idx + RD_LAT + 2, 1);
               if (m_ready) begin
                  got_q.push_back(m_data);
                  got_cyc.push_back(cyc - acc_cyc);
                  if (beat_idx == exp_len - 1) last_xfer = 1'b1;
                  void'(exp_q.pop_front());
                  beat_idx++;
               end
            end
            if (exp_busy) begin
               if (cyc == acc_cyc + 1 || addr_q.size() == 0) addr_q.push_back(mem_addr);
               else if (mem_addr != addr_q[$]) addr_q.push_back(mem_addr);
            end
            if (done) done_cyc = cyc - acc_cyc;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;

            n_busy = exp_busy;
            n_done = 1'b0;
            if (!exp_busy && !exp_done && start) begin
               acc_cyc  = cyc;
               done_cyc = -1;
               got_q.delete();
               got_cyc.delete();
               addr_q.delete();
               exp_q.delete();
               beat_idx = 0;
               exp_len  = int'(length);
               if (length == 0) begin
                  n_done = 1'b1;
               end else begin
                  n_busy = 1'b1;
                  for (int k = 0; k < exp_len; k++)
                     exp_q.push_back(mem[(int'(base_addr) + k) % (1 << ADDR_W)]);
               end
            end
            if (last_xfer) begin
               n_busy = 1'b0;
               n_done = 1'b1;
            end
         end
      end
   end

   function automatic logic rdy(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         1:       return (n % 2) == 0;
         2:       return $urandom_range(0, 1) == 1;
         default: return $urandom_range(0, 3) == 0;
      endcase
   endfunction

   // inject: loop cycle in which a conflicting start is pulsed (-1 = never)
   task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                            input int mode, input int inject);
      bit fin;
      int limit;
      int mism;
      fin   = 1'b0;
      limit = 8 * int'(l) + 40;
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      length    = l;
      m_ready   = rdy(mode, 0);
      for (int n = 1; n < limit; n++) begin
         @(posedge clk); #1;
         if (done) begin
            fin = 1'b1;
            break;
         end
         start = (n == inject);
         if (n == inject) begin
            base_addr = b ^ 10'h0AA;
            length    = l + 11'd3;
         end
         m_ready = rdy(mode, n);
      end
      start = 1'b0;
      @(negedge clk);
      chk("finished_in_time", fin, 1);
      chk("model_drained", exp_q.size(), 0);
      chk("beat_count", got_q.size(), int'(l));
      chk("addr_count", addr_q.size(), int'(l));
      mism = 0;
      for (int k = 0; k < addr_q.size(); k++)
         if (addr_q[k] != ADDR_W'((int'(b) + k) % (1 << ADDR_W))) mism++;
      chk("addr_seq", mism, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fin;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      m_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic burst, ready held high
      run_burst(10'h010, 11'd4, 0, -1);
      for (int k = 0; k < 4 && k < got_q.size(); k++)
         chk("b1_data", got_q[k], 8'h10 + k);
      if (got_cyc.size() == 4) begin
         chk("b1_first_cycle", got_cyc[0], 4);
         chk("b1_last_cycle", got_cyc[3], 7);
      end
      chk("b1_done_cycle", done_cyc, 8);

      // Address wrap
      run_burst(10'h3FE, 11'd4, 0, -1);
      if (addr_q.size() == 4) begin
         chk("wrap_addr0", addr_q[0], 10'h3FE);
         chk("wrap_addr1", addr_q[1], 10'h3FF);
         chk("wrap_addr2", addr_q[2], 10'h000);
         chk("wrap_addr3", addr_q[3], 10'h001);
      end
      if (got_q.size() == 4) begin
         chk("wrap_data0", got_q[0], 8'hFE);
         chk("wrap_data2", got_q[2], 8'h00);
      end

      // Toggling ready
      run_burst(10'h020, 11'd8, 1, -1);
      if (got_q.size() == 8) chk("toggle_last_data", got_q[7], 8'h27);

      // Zero length
      run_burst(10'h055, 11'd0, 0, -1);
      chk("len0_done_cycle", done_cyc, 1);

      // Sustained throughput
      run_burst(10'h0A0, 11'd20, 0, -1);
      if (got_cyc.size() == 20) chk("tp_last_cycle", got_cyc[19], 23);
      chk("tp_done_cycle", done_cyc, 24);

      // Start during RUN is ignored
      run_burst(10'h130, 11'd8, 0, 3);
      if (got_q.size() == 8) chk("ign_first_data", got_q[0], 8'h30);

      // Reset mid-burst
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 10'h040;
      length    = 11'd16;
      m_ready   = 1'b1;
      fin       = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (got_q.size() >= 3) begin
            fin = 1'b1;
            break;
         end
      end
      chk("rst_3rd_beat_seen", fin, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      repeat (5) @(posedge clk);
      run_burst(10'h050, 11'd2, 0, -1);
      if (got_q.size() == 2) begin
         chk("post_rst_data0", got_q[0], 8'h50);
         chk("post_rst_data1", got_q[1], 8'h51);
      end

      // Randomized bursts over random memory contents
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
      for (int t = 0; t < 14; t++)
         run_burst(ADDR_W'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)),
                   $urandom_range(0, 3), -1);
      run_burst(ADDR_W'($urandom_range(0, 1023)), 11'd1, 3, -1);
      run_burst(ADDR_W'($urandom_range(0, 1023)), 11'd1024, 2, -1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bram_burst_reader.md
BRAM_BURST_READER -- requirements
Module: bram_burst_reader

Interface
REQ-001 Parameter ADDR_W, 10, BRAM address width (1024 locations).
REQ-002 Parameter DATA_W, 8, BRAM and stream data width.
REQ-003 Parameter RD_LAT, 2, fixed BRAM read latency in cycles (address cycle to data cycle).
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  burst request, sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first BRAM address of the burst.
REQ-008 length  in  ADDR_W+1  beat count, 0..1024.
REQ-009 mem_addr  out  ADDR_W  read address to BRAM port (port write enable tied low at top level).
REQ-010 mem_data  in  DATA_W  BRAM read data; valid RD_LAT cycles after the matching mem_addr cycle.
REQ-011 m_data  out  DATA_W  output stream data.
REQ-012 m_valid  out  1  output stream valid.
REQ-013 m_ready  in  1  output stream ready; beat transfers when m_valid and m_ready are both high.
REQ-014 m_last  out  1  high with the final beat of a burst.
REQ-015 busy  out  1  burst in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, RUN (issuing addresses), DRAIN (all issued, beats pending), DONE (one cycle).
REQ-018 IDLE: start=1 with length>0 latches base_addr and length -> RUN; start=1 with length=0 -> DONE directly; no beats are produced.
REQ-019 start is ignored in every state other than IDLE.
REQ-020 Issue: in RUN, one address per cycle when credit allows; a 1-bit issue tag travels through an RD_LAT-deep shift register alongside each address.
REQ-021 Address sequence: base_addr, base_addr+1, ..., modulo 2^ADDR_W, so 0x3FF is followed by 0x000.
REQ-022 Capture: when the tag emerges, mem_data is written into a (RD_LAT+1)-entry FIFO in the same cycle.
REQ-023 Credit: issue only while fifo_count + in_flight - pop_this_cycle < RD_LAT+1; the FIFO shall never overflow under any m_ready pattern.
REQ-024 Latency: address issued in cycle t produces m_valid no earlier than cycle t+RD_LAT+1; first issue occurs in the cycle after start is accepted.
REQ-025 Throughput: with m_ready held high, one beat per cycle sustained after the first.
REQ-026 Stream: m_data/m_valid are driven from the FIFO head; once m_valid is high, m_valid and m_data hold until the beat transfers.
REQ-027 m_last is high only on the beat whose index equals length-1.
REQ-028 RUN -> DRAIN after the final address issues; DRAIN -> DONE in the cycle after the m_last beat transfers; DONE -> IDLE unconditionally.
REQ-029 done=1 only in DONE; busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-030 mem_addr holds its last value when not issuing.

Reset
REQ-031 rst=1: FSM -> IDLE; FIFO, issue tags, beat and address counters cleared.
REQ-032 Reset values: m_valid=0, m_last=0, busy=0, done=0, m_data=0, mem_addr=0.
REQ-033 Reset mid-burst aborts the burst; data in flight is discarded and done is not pulsed.

Structure
REQ-034 ADDR_W, DATA_W, RD_LAT defaults and FSM state encoding are defined in a shared package bram_pkg.
REQ-035 The FIFO is one sub-module, bram_rd_fifo (depth RD_LAT+1, count output, same-cycle push and pop allowed).

Verification
Preload mem[i]=i[7:0]; cycle 0 = start-accept cycle.
REQ-036 base=0x010, len=4, m_ready=1 -> beats 0x10,0x11,0x12,0x13 valid in cycles 4-7; m_last in cycle 7; done in cycle 8.
REQ-037 base=0x3FE, len=4 -> mem_addr 0x3FE,0x3FF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
REQ-038 len=8, m_ready toggling 1,0,1,0 -> 8 beats in order, no loss or duplicates; m_data stable while stalled; FIFO count never >3.
REQ-039 len=0 -> done in cycle 1; m_valid never asserted; busy stays 0.
REQ-040 rst after the 3rd beat of len=16 -> next cycle m_valid=0, busy=0, no done; a following len=2 burst completes normally.
REQ-041 start pulsed during RUN with a different base -> ignored; the current burst is unchanged.
